dac_spi_writer: RTL and testbench
=================================

Name: dac_spi_writer

Overview:
- SPI transmitter that consumes the {set strobe, 12-bit value} stream from the lab's slow counter and writes each value to a 12-bit serial DAC (MCP4921-style: 16-bit frame, MSB first, latched by an LDAC pulse).
- Sits between the counter and the DAC header pins.
- Includes a one-deep pending buffer so a strobe that arrives mid-frame is not lost.

Parameters:
- HALF, default 5: SCLK half-period in clk cycles (5 gives 10 MHz SCLK at 100 MHz clk). Must be at least 1.
- CONFIG, default 4'b0011: frame header bits [15:12] (A/B=0, BUF=0, GA=1 for 1x gain, SHDN=1 for active).

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  reset, asynchronous, active-high
- set  input  1  one-cycle load strobe
- value  input  12  DAC code, sampled in the cycle set=1
- busy  output  1  high while a frame is in progress, through the done cycle
- done  output  1  one-cycle pulse when a frame completes (after the LDAC pulse)
- overrun  output  1  one-cycle pulse when a pending value is overwritten
- cs_n  output  1  DAC chip select, active low
- sclk  output  1  SPI clock, idle low; DAC samples mosi on the rising edge
- mosi  output  1  serial data, MSB first
- ldac_n  output  1  DAC latch strobe, active low

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - Outputs: cs_n=1, sclk=0, mosi=0, ldac_n=1, busy=0, done=0, overrun=0.
  - State=IDLE; pending buffer cleared; shift register and timer cleared.
  - The DAC discards a partial frame when cs_n rises, so no recovery is needed.
- Frame word: {CONFIG, value} = 16 bits, sent bit 15 first.
- Phase timer: counts 0..HALF-1. Every state below lasts exactly HALF cycles unless stated otherwise.
- IDLE:
  - Outputs at idle levels.
  - If set=1, or the pending buffer is valid: load the shift register (from value if set=1, otherwise from the pending buffer) and go to SETUP on the next cycle.
  - If set=1 and the pending buffer is valid in the same cycle: set wins, the pending buffer is cleared, and overrun pulses.
- SETUP: cs_n=0, sclk=0, mosi=bit15, busy=1.
- HIGH: sclk=1; mosi holds.
- LOW: sclk=0. On entry, the shift register shifts left and mosi takes the next bit; after bit 0 it shifts in 0.
- Bit counter 0..15 increments on each LOW→HIGH transition. After the LOW that follows the 16th HIGH, go to LATCH. That final LOW also serves as cs hold time.
- LATCH: cs_n=1, ldac_n=0, sclk=0, mosi=0.
- DONE: lasts 1 cycle. ldac_n=1, done=1, busy=1. Next state is IDLE.
- Timing at default HALF=5:
  - cs_n low for 33·HALF = 165 cycles.
  - ldac_n low for 5 cycles.
  - Exactly 16 sclk rising edges per frame.
  - The set cycle is T; cs_n falls at T+1 and done pulses at T+1+34·HALF = T+171.
- set while busy (any state except IDLE, including DONE):
  - value is written into the pending buffer and the buffer is marked valid.
  - If the buffer was already valid, it is overwritten (newest wins) and overrun pulses the following cycle.
  - The frame in progress is never altered.
- Back-to-back frames: a pending frame starts from IDLE. IDLE therefore lasts exactly 1 cycle, giving a minimum cs_n-high gap of HALF+2 cycles.
- set asserted in the IDLE cycle itself starts a frame directly; the pending buffer is not used.
- Widths: value is taken as-is with no saturation. CONFIG is truncated to 4 bits.
- Registers: all outputs are registered, with no combinational paths from inputs to outputs.

Test Plan:
- Single write: rst pulse, then set with value=12'hA5C at cycle T.
  - cs_n falls at T+1.
  - Bits sampled on 16 sclk rises = 16'h3A5C.
  - ldac_n low 5 cycles after cs_n rises.
  - done pulses at T+171; busy high T+1..T+171.
- Boundary codes: values 12'h000 and 12'hFFF.
  - Frames read 16'h3000 and 16'h3FFF.
  - mosi is 0 outside cs_n-low.
- Pending: set 12'h111 at T, then set 12'h222 at T+50.
  - Second frame starts 2 cycles after the first done, carries 16'h3222, and overrun stays 0.
- Overrun: sets at T, T+20 (12'h0AA), and T+40 (12'h0BB).
  - overrun pulses once at T+41.
  - Second frame carries 16'h30BB; exactly two frames are sent.
- Reset mid-frame: assert rst at T+80 of a frame.
  - Outputs return to idle levels in the same cycle, with no done pulse.
  - After release, set 12'h123 produces a clean frame 16'h3123.
- HALF=1 and CONFIG=4'b1000:
  - sclk period is 2 cycles; cs_n low for 33 cycles.
  - Frame header bits read 4'b1000.
  - done pulses at T+35.

Source files
------------

// File: rtl/dac_spi_writer.sv
// SPI writer for a 12-bit MCP4921-style DAC: sends {CONFIG, value} MSB first, then pulses LDAC.
// A one-deep pending buffer holds a value that arrives while a frame is in flight.
module dac_spi_writer #(
    parameter int          HALF   = 5,
    parameter logic [3:0]  CONFIG = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set,
    input  logic [11:0] value,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    output logic        ldac_n
);

    localparam int            TW    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [TW-1:0] TLAST = TW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        LATCH,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [15:0]   shreg, shreg_n;
    logic [11:0]   pend, pend_n;
    logic          pend_vld, pend_vld_n;
    logic          phase_end;

    logic busy_d, done_d, overrun_d, cs_n_d, sclk_d, mosi_d, ldac_n_d;

    assign phase_end = (timer == TLAST);

    always_comb begin
        state_n    = state;
        timer_n    = '0;
        bitcnt_n   = bitcnt;
        shreg_n    = shreg;
        pend_n     = pend;
        pend_vld_n = pend_vld;
        overrun_d  = set && pend_vld;

        case (state)
            IDLE: begin
                bitcnt_n = '0;
                if (set) begin
                    // A fresh strobe beats a stale pending value.
                    shreg_n    = {CONFIG, value};
                    pend_vld_n = 1'b0;
                    state_n    = SETUP;
                end else if (pend_vld) begin
                    shreg_n    = {CONFIG, pend};
                    pend_vld_n = 1'b0;
                    state_n    = SETUP;
                end
            end
            SETUP: begin
                timer_n = phase_end ? '0 : timer + 1'b1;
                if (phase_end) state_n = HIGH;
            end
            HIGH: begin
                timer_n = phase_end ? '0 : timer + 1'b1;
                if (phase_end) begin
                    state_n = LOW;
                    shreg_n = {shreg[14:0], 1'b0};
                end
            end
            LOW: begin
                timer_n = phase_end ? '0 : timer + 1'b1;
                if (phase_end) begin
                    if (bitcnt == 4'd15) begin
                        state_n = LATCH;
                    end else begin
                        state_n  = HIGH;
                        bitcnt_n = bitcnt + 4'd1;
                    end
                end
            end
            LATCH: begin
                timer_n = phase_end ? '0 : timer + 1'b1;
                if (phase_end) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state != IDLE && set) begin
            pend_n     = value;
            pend_vld_n = 1'b1;
        end

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        busy_d   = (state_n != IDLE);
        done_d   = (state_n == DONE);
        cs_n_d   = !(state_n == SETUP || state_n == HIGH || state_n == LOW);
        sclk_d   = (state_n == HIGH);
        mosi_d   = !cs_n_d && shreg_n[15];
        ldac_n_d = (state_n != LATCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ldac_n   <= 1'b1;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            pend     <= pend_n;
            pend_vld <= pend_vld_n;
            busy     <= busy_d;
            done     <= done_d;
            overrun  <= overrun_d;
            cs_n     <= cs_n_d;
            sclk     <= sclk_d;
            mosi     <= mosi_d;
            ldac_n   <= ldac_n_d;
        end
    end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Directed bench for dac_spi_writer: dut0 uses defaults, dut1 uses HALF=1 and CONFIG=4'b1000.
// A negedge monitor decodes SPI frames and timestamps every strobe by cycle number.
module tb_dac_spi_writer;

    logic        clk = 1'b0;
    logic [1:0]  rst, set;
    logic [11:0] value0, value1;
    logic [1:0]  busy, done, overrun, cs_n, sclk, mosi, ldac_n;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dac_spi_writer u_dut0 (
        .clk(clk), .rst(rst[0]), .set(set[0]), .value(value0),
        .busy(busy[0]), .done(done[0]), .overrun(overrun[0]), .cs_n(cs_n[0]),
        .sclk(sclk[0]), .mosi(mosi[0]), .ldac_n(ldac_n[0])
    );

    dac_spi_writer #(.HALF(1), .CONFIG(4'b1000)) u_dut1 (
        .clk(clk), .rst(rst[1]), .set(set[1]), .value(value1),
        .busy(busy[1]), .done(done[1]), .overrun(overrun[1]), .cs_n(cs_n[1]),
        .sclk(sclk[1]), .mosi(mosi[1]), .ldac_n(ldac_n[1])
    );

    // Monitor state, one slot per DUT
    logic [15:0] shr [2];
    logic [15:0] frames [2][16];
    int fnb [2][16];
    int fall_at [2][16];
    int nb[2], cs_fall[2], low_len[2], ldac_fall[2], ldac_len[2];
    int done_cnt[2], done_at[2], ovr_cnt[2], ovr_at[2];
    int busy_rise[2], busy_fall[2], first_rise[2], last_rise[2];
    int mosi_bad[2], fcnt[2];
    logic [1:0] pcs, psclk, pldac, pbusy;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                nb[d] = 0; pcs[d] = 1'b1; psclk[d] = 1'b0; pldac[d] = 1'b1; pbusy[d] = 1'b0;
            end else begin
                if (!cs_n[d] && pcs[d]) begin
                    cs_fall[d] = cyc; nb[d] = 0; shr[d] = 16'h0;
                end
                if (cs_n[d] && !pcs[d]) begin
                    frames[d][fcnt[d] % 16]  = shr[d];
                    fnb[d][fcnt[d] % 16]     = nb[d];
                    fall_at[d][fcnt[d] % 16] = cs_fall[d];
                    low_len[d] = cyc - cs_fall[d];
                    fcnt[d]++;
                end
                if (sclk[d] && !psclk[d]) begin
                    shr[d] = {shr[d][14:0], mosi[d]};
                    nb[d]++;
                    if (nb[d] == 1) first_rise[d] = cyc;
                    last_rise[d] = cyc;
                end
                if (cs_n[d] && mosi[d]) mosi_bad[d]++;
                if (!ldac_n[d] && pldac[d]) ldac_fall[d] = cyc;
                if (ldac_n[d] && !pldac[d]) ldac_len[d] = cyc - ldac_fall[d];
                if (done[d]) begin done_cnt[d]++; done_at[d] = cyc; end
                if (overrun[d]) begin ovr_cnt[d]++; ovr_at[d] = cyc; end
                if (busy[d] && !pbusy[d]) busy_rise[d] = cyc;
                if (!busy[d] && pbusy[d]) busy_fall[d] = cyc;
                pcs[d] = cs_n[d]; psclk[d] = sclk[d]; pldac[d] = ldac_n[d]; pbusy[d] = busy[d];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds set for one cycle; t is the set cycle, and on return we are in cycle t+1.
    task automatic do_set(input int d, input logic [11:0] v, output int t);
        if (d == 0) value0 = v; else value1 = v;
        set[d] = 1'b1;
        t = cyc;
        tick(1);
        set[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int target, input int bound);
        int k = 0;
        while (done_cnt[d] < target && k < bound) begin
            tick(1);
            k++;
        end
        if (done_cnt[d] < target) begin
            errors++; checks++;
            $display("FAIL wait_done dut%0d: got %0d done pulses, want %0d", d, done_cnt[d], target);
        end
    endtask

    task automatic test_reset();
        rst = 2'b11; set = 2'b00; value0 = '0; value1 = '0;
        tick(3);
        for (int d = 0; d < 2; d++) begin
            if ({cs_n[d], sclk[d], mosi[d], ldac_n[d], busy[d], done[d], overrun[d]} !== 7'b1001000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %b want 1001000", d,
                         {cs_n[d], sclk[d], mosi[d], ldac_n[d], busy[d], done[d], overrun[d]});
            end
            checks++;
        end
        rst = 2'b00;
        tick(3);
        if ({cs_n[0], sclk[0], mosi[0], ldac_n[0], busy[0], done[0], overrun[0]} !== 7'b1001000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 1001000",
                     {cs_n[0], sclk[0], mosi[0], ldac_n[0], busy[0], done[0], overrun[0]});
        end
        checks++;
    endtask

    task automatic test_single();
        int t, i0;
        i0 = fcnt[0];
        do_set(0, 12'hA5C, t);
        wait_done(0, done_cnt[0] + 1, 400);
        tick(2);
        if (frames[0][i0 % 16] !== 16'h3A5C) begin errors++; $display("FAIL single_frame: got %h want 3a5c", frames[0][i0 % 16]); end
        checks++;
        if (fnb[0][i0 % 16] != 16) begin errors++; $display("FAIL single_bits: got %0d want 16", fnb[0][i0 % 16]); end
        checks++;
        if (fall_at[0][i0 % 16] != t + 1) begin errors++; $display("FAIL single_cs_fall: got %0d want %0d", fall_at[0][i0 % 16], t + 1); end
        checks++;
        if (low_len[0] != 165) begin errors++; $display("FAIL single_cs_low: got %0d want 165", low_len[0]); end
        checks++;
        if (ldac_fall[0] != t + 166 || ldac_len[0] != 5) begin
            errors++; $display("FAIL single_ldac: got fall %0d len %0d want %0d len 5", ldac_fall[0], ldac_len[0], t + 166);
        end
        checks++;
        if (done_at[0] != t + 171) begin errors++; $display("FAIL single_done: got %0d want %0d", done_at[0], t + 171); end
        checks++;
        if (busy_rise[0] != t + 1 || busy_fall[0] != t + 172) begin
            errors++; $display("FAIL single_busy: got %0d..%0d want %0d..%0d", busy_rise[0], busy_fall[0], t + 1, t + 172);
        end
        checks++;
        if (first_rise[0] != t + 6 || last_rise[0] != t + 156) begin
            errors++; $display("FAIL single_sclk: got %0d..%0d want %0d..%0d", first_rise[0], last_rise[0], t + 6, t + 156);
        end
        checks++;
    endtask

    task automatic test_boundary();
        int t, i0;
        i0 = fcnt[0];
        do_set(0, 12'h000, t);
        wait_done(0, done_cnt[0] + 1, 400);
        do_set(0, 12'hFFF, t);
        wait_done(0, done_cnt[0] + 1, 400);
        tick(2);
        if (frames[0][i0 % 16] !== 16'h3000) begin errors++; $display("FAIL boundary_zero: got %h want 3000", frames[0][i0 % 16]); end
        checks++;
        if (frames[0][(i0 + 1) % 16] !== 16'h3FFF) begin errors++; $display("FAIL boundary_ones: got %h want 3fff", frames[0][(i0 + 1) % 16]); end
        checks++;
        if (mosi_bad[0] != 0) begin errors++; $display("FAIL mosi_idle: got %0d high samples want 0", mosi_bad[0]); end
        checks++;
    endtask

    task automatic test_pending();
        int t, t2, i0, o0;
        i0 = fcnt[0]; o0 = ovr_cnt[0];
        do_set(0, 12'h111, t);
        tick(49);
        do_set(0, 12'h222, t2);
        wait_done(0, done_cnt[0] + 2, 600);
        tick(2);
        if (frames[0][i0 % 16] !== 16'h3111 || frames[0][(i0 + 1) % 16] !== 16'h3222) begin
            errors++; $display("FAIL pending_frames: got %h %h want 3111 3222", frames[0][i0 % 16], frames[0][(i0 + 1) % 16]);
        end
        checks++;
        if (fall_at[0][(i0 + 1) % 16] != t + 173) begin
            errors++; $display("FAIL pending_start: got %0d want %0d", fall_at[0][(i0 + 1) % 16], t + 173);
        end
        checks++;
        if (ovr_cnt[0] != o0) begin errors++; $display("FAIL pending_overrun: got %0d pulses want 0", ovr_cnt[0] - o0); end
        checks++;
    endtask

    task automatic test_overrun();
        int t, tx, i0, o0;
        i0 = fcnt[0]; o0 = ovr_cnt[0];
        do_set(0, 12'h055, t);
        tick(19);
        do_set(0, 12'h0AA, tx);
        tick(19);
        do_set(0, 12'h0BB, tx);
        wait_done(0, done_cnt[0] + 2, 600);
        tick(300);
        if (ovr_cnt[0] - o0 != 1 || ovr_at[0] != t + 41) begin
            errors++; $display("FAIL overrun_pulse: got %0d pulses at %0d want 1 at %0d", ovr_cnt[0] - o0, ovr_at[0], t + 41);
        end
        checks++;
        if (frames[0][i0 % 16] !== 16'h3055 || frames[0][(i0 + 1) % 16] !== 16'h30BB) begin
            errors++; $display("FAIL overrun_frames: got %h %h want 3055 30bb", frames[0][i0 % 16], frames[0][(i0 + 1) % 16]);
        end
        checks++;
        if (fcnt[0] - i0 != 2) begin errors++; $display("FAIL overrun_count: got %0d frames want 2", fcnt[0] - i0); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int t, tx, i0, d0;
        do_set(0, 12'h456, t);
        tick(69);
        do_set(0, 12'h777, tx);
        tick(9);
        d0 = done_cnt[0];
        rst[0] = 1'b1;
        #1;
        if ({cs_n[0], sclk[0], mosi[0], ldac_n[0], busy[0], done[0], overrun[0]} !== 7'b1001000) begin
            errors++; $display("FAIL reset_mid_outputs: got %b want 1001000",
                               {cs_n[0], sclk[0], mosi[0], ldac_n[0], busy[0], done[0], overrun[0]});
        end
        checks++;
        tick(3);
        rst[0] = 1'b0;
        tick(20);
        if (busy[0] !== 1'b0 || cs_n[0] !== 1'b1) begin
            errors++; $display("FAIL reset_clears_pending: got busy %b cs_n %b want 0 1", busy[0], cs_n[0]);
        end
        checks++;
        tick(200);
        if (done_cnt[0] != d0) begin errors++; $display("FAIL reset_no_done: got %0d pulses want 0", done_cnt[0] - d0); end
        checks++;
        i0 = fcnt[0];
        do_set(0, 12'h123, t);
        wait_done(0, done_cnt[0] + 1, 400);
        tick(2);
        if (frames[0][i0 % 16] !== 16'h3123 || fnb[0][i0 % 16] != 16) begin
            errors++; $display("FAIL reset_recover: got %h/%0d bits want 3123/16", frames[0][i0 % 16], fnb[0][i0 % 16]);
        end
        checks++;
    endtask

    task automatic test_half1();
        int t, i0;
        i0 = fcnt[1];
        do_set(1, 12'h5A3, t);
        wait_done(1, done_cnt[1] + 1, 200);
        tick(2);
        if (frames[1][i0 % 16] !== 16'h85A3 || fnb[1][i0 % 16] != 16) begin
            errors++; $display("FAIL half1_frame: got %h/%0d bits want 85a3/16", frames[1][i0 % 16], fnb[1][i0 % 16]);
        end
        checks++;
        if (low_len[1] != 33) begin errors++; $display("FAIL half1_cs_low: got %0d want 33", low_len[1]); end
        checks++;
        if (first_rise[1] != t + 2 || last_rise[1] != t + 32) begin
            errors++; $display("FAIL half1_sclk: got %0d..%0d want %0d..%0d", first_rise[1], last_rise[1], t + 2, t + 32);
        end
        checks++;
        if (done_at[1] != t + 35) begin errors++; $display("FAIL half1_done: got %0d want %0d", done_at[1], t + 35); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_pending();
        test_overrun();
        test_reset_mid();
        test_half1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
